button_debouncer: RTL and testbench
===================================

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default CLOCK_FREQUENCY_HZ / 100 (500000, i.e. 10 ms), meaning the number of consecutive stable samples required to accept a level change; legal range >= 1.
REQ-002 The block SHALL have parameter BUTTON_ACTIVE_LOW, default 1, meaning raw input low = pressed when 1 and raw input high = pressed when 0.
REQ-003 The block SHALL have parameter LONG_PRESS_CYCLES, default CLOCK_FREQUENCY_HZ (1 s), meaning the hold time for a long press; used only with LONG_PRESS_EN.
REQ-004 clock  input  1  system clock, rising-edge; one clock; reset is asynchronous and active-high.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 button  input  1  raw, asynchronous push-button level.
REQ-007 level  output  1  debounced, polarity-normalised button state (1 = pressed).
REQ-008 pressed  output  1  one-cycle pulse on accepted press.
REQ-009 released  output  1  one-cycle pulse on accepted release.
REQ-010 long_press  output  1  one-cycle pulse on accepted long press; present only with LONG_PRESS_EN.

Function
REQ-011 button SHALL pass through a two-flop synchroniser, then be normalised by BUTTON_ACTIVE_LOW into signal act.
REQ-012 FSM states SHALL be STATE_RELEASED, STATE_PRESS_PENDING, STATE_PRESSED, STATE_RELEASE_PENDING.
REQ-013 RELEASED with act=1 SHALL go to PRESS_PENDING and load count=1; act=0 holds.
REQ-014 PRESS_PENDING: act=1 and count<N SHALL increment count; act=1 and count==N SHALL go to PRESSED; act=0 SHALL return to RELEASED and clear count, with no pulse.
REQ-015 PRESSED / RELEASE_PENDING SHALL mirror REQ-013/014 with act inverted, ending in RELEASED.
REQ-016 pressed SHALL be registered high for exactly the cycle after the PRESS_PENDING->PRESSED transition; released likewise for RELEASE_PENDING->RELEASED.
REQ-017 Latency: for raw input stable and active from edge 1, pressed SHALL be high during the cycle following edge N+3 (N = DEBOUNCE_CYCLES); release is symmetric.
REQ-018 level SHALL be 1 in PRESSED and RELEASE_PENDING, 0 otherwise, and SHALL be registered.
REQ-019 Glitches shorter than N samples SHALL produce no pulse and no level change.
REQ-020 Counter width SHALL be $clog2(N+1); count SHALL never exceed N (no wrap).
REQ-021 pressed and released SHALL never be high in the same cycle.

Reset
REQ-022 Asserting reset SHALL immediately force state RELEASED, count 0, level 0, and pressed/released/long_press 0.
REQ-023 Synchroniser flops SHALL reset to the inactive raw level, so a released button produces no spurious press after reset.
REQ-024 Reset mid-debounce or mid-press SHALL discard all progress, with no pulse on deassertion; a still-held button SHALL be re-debounced from scratch (full N+3 latency).

Configuration
REQ-025 Macro LONG_PRESS_EN defined: a hold counter of width $clog2(LONG_PRESS_CYCLES+1) SHALL count while in PRESSED, and long_press SHALL pulse once when it reaches LONG_PRESS_CYCLES; the counter saturates, and a new press is required for another pulse.
REQ-026 The hold counter SHALL clear on entry to PRESSED from PRESS_PENDING and SHALL hold its value through RELEASE_PENDING->PRESSED glitch recovery.
REQ-027 Macro LONG_PRESS_EN undefined: the long_press port, the hold counter and LONG_PRESS_CYCLES usage SHALL be absent; all other behaviour is identical.

Structure
REQ-028 Package definitions SHALL gain typedef enum btn_state_t (four states above) and localparam DEBOUNCE_CYCLES_10MS = CLOCK_FREQUENCY_HZ / 100; button_debouncer imports it.
REQ-029 The two-flop synchroniser SHALL be a separate sub-module, synchronizer, reset asynchronously to a parameterised value; everything else stays in button_debouncer.

Verification (bench uses N=4, LONG_PRESS_CYCLES=10, BUTTON_ACTIVE_LOW=1)
REQ-030 Hold button=0 from edge 1 -> pressed high only in the cycle after edge 7, level=1 from then on.
REQ-031 button=0 for 3 cycles then 1 -> no pressed pulse, level stays 0, state returns to RELEASED.
REQ-032 Stable press, then button=1 for 10 cycles -> single released pulse 7 edges after the release edge, level=0.
REQ-033 Press held, 2-cycle release glitch -> no released pulse, level stays 1; with LONG_PRESS_EN, exactly one long_press pulse after 10 cycles in PRESSED.
REQ-034 Assert reset during PRESS_PENDING (count=2) with button held -> outputs 0 immediately; after deassertion, pressed appears N+3 edges later.
REQ-035 Random bouncing on press and release -> pressed/released counts are equal, never overlap, and level matches the last accepted state.

Source files
------------

// File: rtl/button_debouncer_pkg.sv
// Shared types and constants for the push-button debouncer.
package button_debouncer_pkg;

    localparam int unsigned CLOCK_FREQUENCY_HZ   = 50_000_000;
    localparam int unsigned DEBOUNCE_CYCLES_10MS = CLOCK_FREQUENCY_HZ / 100;

    typedef enum logic [1:0] {
        STATE_RELEASED,
        STATE_PRESS_PENDING,
        STATE_PRESSED,
        STATE_RELEASE_PENDING
    } btn_state_t;

    // Debounced level implied by a state: high once a press has been accepted.
    function automatic logic state_level(input btn_state_t s);
        return (s == STATE_PRESSED) || (s == STATE_RELEASE_PENDING);
    endfunction

endpackage

// File: rtl/synchronizer.sv
// Two-flop synchroniser for a single asynchronous level, with a selectable reset value.
module synchronizer #(
    parameter bit RESET_VALUE = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: synchronise, normalise polarity, accept level changes after a stable run.
// Optional long-press detection is enabled by defining LONG_PRESS_EN.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_10MS,
    parameter bit          BUTTON_ACTIVE_LOW = 1'b1
`ifdef LONG_PRESS_EN
    ,
    parameter int unsigned LONG_PRESS_CYCLES = CLOCK_FREQUENCY_HZ
`endif
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic level,
    output logic pressed,
    output logic released
`ifdef LONG_PRESS_EN
    ,
    output logic long_press
`endif
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             button_sync;
    logic             act;
    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             level_d, pressed_d, released_d;

    // Idle raw level is the reset value so a released button looks inactive after reset.
    synchronizer #(
        .RESET_VALUE(BUTTON_ACTIVE_LOW)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (button),
        .q     (button_sync)
    );

    assign act = BUTTON_ACTIVE_LOW ? ~button_sync : button_sync;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= STATE_RELEASED;
            count_q  <= '0;
            level    <= 1'b0;
            pressed  <= 1'b0;
            released <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            level    <= level_d;
            pressed  <= pressed_d;
            released <= released_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        pressed_d  = 1'b0;
        released_d = 1'b0;
        case (state_q)
            STATE_RELEASED: begin
                if (act) begin
                    state_d = STATE_PRESS_PENDING;
                    count_d = CNT_W'(1);
                end
            end
            STATE_PRESS_PENDING: begin
                if (!act) begin
                    state_d = STATE_RELEASED;
                    count_d = '0;
                end else if (count_q == CNT_W'(DEBOUNCE_CYCLES)) begin
                    state_d   = STATE_PRESSED;
                    count_d   = '0;
                    pressed_d = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            STATE_PRESSED: begin
                if (!act) begin
                    state_d = STATE_RELEASE_PENDING;
                    count_d = CNT_W'(1);
                end
            end
            STATE_RELEASE_PENDING: begin
                if (act) begin
                    state_d = STATE_PRESSED;
                    count_d = '0;
                end else if (count_q == CNT_W'(DEBOUNCE_CYCLES)) begin
                    state_d    = STATE_RELEASED;
                    count_d    = '0;
                    released_d = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = STATE_RELEASED;
                count_d = '0;
            end
        endcase
        level_d = state_level(state_d);
    end

`ifdef LONG_PRESS_EN
    localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_press_d;

    // Hold time accumulates only while PRESSED; a release glitch pauses it rather than clearing it.
    always_comb begin
        hold_d       = hold_q;
        long_press_d = 1'b0;
        if ((state_q == STATE_PRESS_PENDING) && (state_d == STATE_PRESSED)) begin
            hold_d = '0;
        end else if ((state_q == STATE_PRESSED) && (hold_q < HOLD_W'(LONG_PRESS_CYCLES))) begin
            hold_d       = hold_q + HOLD_W'(1);
            long_press_d = (hold_d == HOLD_W'(LONG_PRESS_CYCLES));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_q     <= '0;
            long_press <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            long_press <= long_press_d;
        end
    end
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with N=4, active-low button, long press of 10 cycles.
module tb_button_debouncer;

    logic clk = 1'b0;
    logic reset;
    logic button;
    logic level, pressed, released;
`ifdef LONG_PRESS_EN
    logic long_press;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic button;
        logic level;
        logic pressed;
        logic released;
    } vec_t;

    vec_t vecs[$];

    logic mon_en = 1'b0;
    int   p_cnt = 0, r_cnt = 0, overlap_cnt = 0, order_err = 0;
    logic last_acc = 1'b0;

    always #5 clk = ~clk;

    button_debouncer #(
        .DEBOUNCE_CYCLES   (4),
        .BUTTON_ACTIVE_LOW (1'b1)
`ifdef LONG_PRESS_EN
        ,
        .LONG_PRESS_CYCLES (10)
`endif
    ) dut (
        .clock    (clk),
        .reset    (reset),
        .button   (button),
        .level    (level),
        .pressed  (pressed),
        .released (released)
`ifdef LONG_PRESS_EN
        ,
        .long_press (long_press)
`endif
    );

    // Pulse bookkeeping for the bouncing test: pulses must alternate and never coincide.
    always @(negedge clk) begin
        if (mon_en) begin
            if (pressed && released) overlap_cnt <= overlap_cnt + 1;
            if (pressed) begin
                p_cnt <= p_cnt + 1;
                if (last_acc) order_err <= order_err + 1;
                last_acc <= 1'b1;
            end
            if (released) begin
                r_cnt <= r_cnt + 1;
                if (!last_acc) order_err <= order_err + 1;
                last_acc <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    task automatic check_int(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic step(input logic b);
        button = b;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        button = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic add(input logic b, input logic l, input logic p, input logic r, input int n);
        for (int i = 0; i < n; i++) vecs.push_back({b, l, p, r});
    endtask

    initial begin
        // Vector table: one entry per clock edge, outputs expected after that edge.
        add(1'b0, 1'b0, 1'b0, 1'b0, 6);   // stable press: pending
        add(1'b0, 1'b1, 1'b1, 1'b0, 1);   // accepted at edge 7
        add(1'b0, 1'b1, 1'b0, 1'b0, 2);
        add(1'b1, 1'b1, 1'b0, 1'b0, 6);   // stable release: pending
        add(1'b1, 1'b0, 1'b0, 1'b1, 1);   // accepted 7 edges after release edge
        add(1'b1, 1'b0, 1'b0, 1'b0, 3);
        add(1'b0, 1'b0, 1'b0, 1'b0, 3);   // 3-cycle glitch: rejected
        add(1'b1, 1'b0, 1'b0, 1'b0, 5);
        add(1'b0, 1'b0, 1'b0, 1'b0, 5);   // shortest accepted tap
        add(1'b1, 1'b0, 1'b0, 1'b0, 1);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1);
        add(1'b1, 1'b1, 1'b0, 1'b0, 4);
        add(1'b1, 1'b0, 1'b0, 1'b1, 1);
        add(1'b1, 1'b0, 1'b0, 1'b0, 2);

        reset  = 1'b1;
        button = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_level", level, 1'b0);
        check("reset_pressed", pressed, 1'b0);
        check("reset_released", released, 1'b0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].button);
            check($sformatf("vec%0d_level", i), level, vecs[i].level);
            check($sformatf("vec%0d_pressed", i), pressed, vecs[i].pressed);
            check($sformatf("vec%0d_released", i), released, vecs[i].released);
`ifdef LONG_PRESS_EN
            check($sformatf("vec%0d_long_press", i), long_press, 1'b0);
`endif
        end

        // Held press with a 2-cycle release glitch; long press lands at edge 19.
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            step((e == 10 || e == 11) ? 1'b1 : 1'b0);
            check($sformatf("glitch_e%0d_level", e), level, (e >= 7) ? 1'b1 : 1'b0);
            check($sformatf("glitch_e%0d_pressed", e), pressed, (e == 7) ? 1'b1 : 1'b0);
            check($sformatf("glitch_e%0d_released", e), released, 1'b0);
`ifdef LONG_PRESS_EN
            check($sformatf("glitch_e%0d_long_press", e), long_press, (e == 19) ? 1'b1 : 1'b0);
`endif
        end
        for (int e = 1; e <= 10; e++) begin
            step(1'b1);
            check($sformatf("long_rel_e%0d_released", e), released, (e == 7) ? 1'b1 : 1'b0);
        end
        check("long_rel_level", level, 1'b0);

        // Reset in PRESS_PENDING (count=2) with the button still held.
        do_reset();
        repeat (4) step(1'b0);
        reset = 1'b1;
        #1;
        check("rst_pend_level", level, 1'b0);
        check("rst_pend_pressed", pressed, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step(1'b0);
            check($sformatf("rst_pend_e%0d_pressed", e), pressed, (e == 7) ? 1'b1 : 1'b0);
            check($sformatf("rst_pend_e%0d_level", e), level, (e >= 7) ? 1'b1 : 1'b0);
        end

        // Reset while PRESSED: level drops at once, then a full re-debounce.
        reset = 1'b1;
        #1;
        check("rst_held_level", level, 1'b0);
        check("rst_held_released", released, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step(1'b0);
            check($sformatf("rst_held_e%0d_pressed", e), pressed, (e == 7) ? 1'b1 : 1'b0);
            check($sformatf("rst_held_e%0d_released", e), released, 1'b0);
        end

        // Random bouncing around each press and release.
        do_reset();
        mon_en = 1'b1;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 20; i++) step(1'($urandom_range(0, 1)));
            repeat (15) step(1'b0);
            check($sformatf("bounce%0d_press_level", r), level, 1'b1);
            for (int i = 0; i < 20; i++) step(1'($urandom_range(0, 1)));
            repeat (15) step(1'b1);
            check($sformatf("bounce%0d_release_level", r), level, 1'b0);
        end
        step(1'b1);
        mon_en = 1'b0;
        check_int("bounce_pulse_balance", p_cnt, r_cnt);
        check_int("bounce_overlap", overlap_cnt, 0);
        check_int("bounce_order", order_err, 0);
        check("bounce_min_presses", (p_cnt >= 5) ? 1'b1 : 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
